// File: rtl/hit_info_align_queue_pkg.sv
// ---------------------------------------------------------------------------
// hit_info_align_queue_pkg
// Shared sizing constants for the hit-info alignment queue. These are the
// defaults the top level passes down to its storage array.
//   QUEUESIZE           : default number of queue entries (maps to DEPTH)
//   DEFAULT_SSIDBITS    : default SSID tag width
//   DEFAULT_HITINFOBITS : default hit-info payload width
// ---------------------------------------------------------------------------
package hit_info_align_queue_pkg;

    localparam int QUEUESIZE           = 16;
    localparam int DEFAULT_SSIDBITS    = 13;
    localparam int DEFAULT_HITINFOBITS = 16;

endpackage

// File: rtl/hit_info_align_queue_storage.sv
// ---------------------------------------------------------------------------
// hiq_storage
// DEPTH x WIDTH register array for the hit-info queue. It has one synchronous
// write port and one asynchronous read port. The read port provides the
// show-ahead head entry.
// Ports:
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data ({ssid, info})
//   raddr : read address
//   rdata : combinational read data at raddr
// The contents are not reset. The pointers and count in the parent module
// decide which entries are valid.
// ---------------------------------------------------------------------------
module hiq_storage
    import hit_info_align_queue_pkg::*;
#(
    parameter int DEPTH   = QUEUESIZE,
    parameter int PTRBITS = $clog2(DEPTH),
    parameter int WIDTH   = DEFAULT_SSIDBITS + DEFAULT_HITINFOBITS
)(
    input  logic               clk,
    input  logic               we,
    input  logic [PTRBITS-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [PTRBITS-1:0] raddr,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Synchronous write of one entry
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hit_info_align_queue.sv
// ---------------------------------------------------------------------------
// hit_info_align_queue
// Circular-buffer FIFO. It holds per-hit info and its SSID tag while the SSID
// travels through the HNM pipeline. An entry is released on each HNM output
// (pop). The head is show-ahead. There is an optional empty-queue bypass and
// an optional SSID alignment check on each pop.
// Ports:
//   clk, reset              : clock; synchronous active-high reset
//   push, push_ssid/info    : enqueue request and its entry
//   pop, pop_ssid           : dequeue request and the SSID HNM emitted
//   clear_flags             : clears the sticky error flags
//   head_valid/info/ssid    : show-ahead head entry (info/ssid are 0 when invalid)
//   count                   : occupancy, 0..DEPTH
//   empty/full/almost_full  : status decoded from the registered count
//   overflow/underflow      : sticky flags for a dropped push or an empty pop
//   mismatch/mismatch_pulse : sticky flag and one-cycle pulse for an SSID
//                             check failure
// ---------------------------------------------------------------------------
module hit_info_align_queue
    import hit_info_align_queue_pkg::*;
#(
    parameter int DEPTH             = QUEUESIZE,
    parameter int PTRBITS           = $clog2(DEPTH),
    parameter int SSIDBITS          = DEFAULT_SSIDBITS,
    parameter int HITINFOBITS       = DEFAULT_HITINFOBITS,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 2,
    parameter int BYPASS            = 0,
    parameter int CHECK_SSID        = 1
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [SSIDBITS-1:0]    push_ssid,
    input  logic [HITINFOBITS-1:0] push_info,
    input  logic                   pop,
    input  logic [SSIDBITS-1:0]    pop_ssid,
    input  logic                   clear_flags,
    output logic                   head_valid,
    output logic [HITINFOBITS-1:0] head_info,
    output logic [SSIDBITS-1:0]    head_ssid,
    output logic [PTRBITS:0]       count,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   mismatch,
    output logic                   mismatch_pulse
);

    localparam int CW = PTRBITS + 1;
    localparam int EW = SSIDBITS + HITINFOBITS;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFLVL_C  = CW'(ALMOST_FULL_LEVEL);
    localparam bit            BYPASSEN = (BYPASS != 0);
    localparam bit            CHECKEN  = (CHECK_SSID != 0);

    logic [PTRBITS-1:0]     wrPtr;
    logic [PTRBITS-1:0]     rdPtr;
    logic [CW-1:0]          occupancy;
    logic                   overflowFlag;
    logic                   underflowFlag;
    logic                   mismatchFlag;
    logic                   mismatchPulseReg;

    logic [EW-1:0]          rdEntry;
    logic                   isEmpty;
    logic                   isFull;
    logic                   bypassNow;
    logic                   headValidComb;
    logic [HITINFOBITS-1:0] headInfoComb;
    logic [SSIDBITS-1:0]    headSsidComb;
    logic                   popAcc;
    logic                   pushAcc;
    logic                   bypassConsume;
    logic                   wrEn;
    logic                   rdAdv;
    logic                   ssidBad;
    logic                   overflowSet;
    logic                   underflowSet;

    hiq_storage #(
        .DEPTH   (DEPTH),
        .PTRBITS (PTRBITS),
        .WIDTH   (EW)
    ) uStorage (
        .clk   (clk),
        .we    (wrEn & ~reset),
        .waddr (wrPtr),
        .wdata ({push_ssid, push_info}),
        .raddr (rdPtr),
        .rdata (rdEntry)
    );

    // Head selection, accept decisions and error detection for this cycle
    always_comb begin
        isEmpty       = (occupancy == CW'(0));
        isFull        = (occupancy == DEPTH_C);
        bypassNow     = 1'b0;
        headInfoComb  = {HITINFOBITS{1'b0}};
        headSsidComb  = {SSIDBITS{1'b0}};

        // In bypass mode, a push into an empty queue is shown at the head at once.
        if (BYPASSEN && isEmpty && push) begin
            bypassNow = 1'b1;
        end else begin
            bypassNow = 1'b0;
        end

        headValidComb = !isEmpty || bypassNow;

        if (!headValidComb) begin
            headInfoComb = {HITINFOBITS{1'b0}};
            headSsidComb = {SSIDBITS{1'b0}};
        end else if (bypassNow) begin
            headInfoComb = push_info;
            headSsidComb = push_ssid;
        end else begin
            headInfoComb = rdEntry[HITINFOBITS-1:0];
            headSsidComb = rdEntry[EW-1:HITINFOBITS];
        end

        popAcc  = pop && headValidComb;
        // A full queue still takes a push when the same cycle frees a slot.
        pushAcc = push && (!isFull || popAcc);

        // A bypassed entry consumed in the same cycle never touches storage.
        bypassConsume = bypassNow && popAcc;
        wrEn          = pushAcc && !bypassConsume;
        rdAdv         = popAcc && !bypassConsume;

        ssidBad      = CHECKEN && popAcc && (pop_ssid != headSsidComb);
        overflowSet  = push && !pushAcc;
        underflowSet = pop && !headValidComb;
    end

    // Pointers, occupancy and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr            <= {PTRBITS{1'b0}};
            rdPtr            <= {PTRBITS{1'b0}};
            occupancy        <= {CW{1'b0}};
            overflowFlag     <= 1'b0;
            underflowFlag    <= 1'b0;
            mismatchFlag     <= 1'b0;
            mismatchPulseReg <= 1'b0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + PTRBITS'(1);
            end else begin
                wrPtr <= wrPtr;
            end
            if (rdAdv) begin
                rdPtr <= rdPtr + PTRBITS'(1);
            end else begin
                rdPtr <= rdPtr;
            end
            occupancy <= occupancy + CW'(wrEn) - CW'(rdAdv);

            // A new error in the same cycle wins over clear_flags.
            overflowFlag     <= (overflowFlag  && !clear_flags) || overflowSet;
            underflowFlag    <= (underflowFlag && !clear_flags) || underflowSet;
            mismatchFlag     <= (mismatchFlag  && !clear_flags) || ssidBad;
            mismatchPulseReg <= ssidBad;
        end
    end

    assign head_valid     = headValidComb;
    assign head_info      = headInfoComb;
    assign head_ssid      = headSsidComb;
    assign count          = occupancy;
    assign empty          = isEmpty;
    assign full           = isFull;
    assign almost_full    = (occupancy >= AFLVL_C);
    assign overflow       = overflowFlag;
    assign underflow      = underflowFlag;
    assign mismatch       = mismatchFlag;
    assign mismatch_pulse = mismatchPulseReg;

endmodule

// File: tb/tb_hit_info_align_queue.sv
// ---------------------------------------------------------------------------
// tb_hit_info_align_queue
// Directed bench with two instances. Instance "a" has DEPTH=4 and no bypass.
// Instance "b" has DEPTH=4 and the bypass enabled.
// ---------------------------------------------------------------------------
module tb_hit_info_align_queue;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic        aPush, aPop, aClr;
    logic [12:0] aPushSsid, aPopSsid;
    logic [15:0] aPushInfo;
    logic        aHeadValid, aEmpty, aFull, aAf, aOvf, aUdf, aMis, aMisP;
    logic [15:0] aHeadInfo;
    logic [12:0] aHeadSsid;
    logic [2:0]  aCount;

    logic        bPush, bPop, bClr;
    logic [12:0] bPushSsid, bPopSsid;
    logic [15:0] bPushInfo;
    logic        bHeadValid, bEmpty, bFull, bAf, bOvf, bUdf, bMis, bMisP;
    logic [15:0] bHeadInfo;
    logic [12:0] bHeadSsid;
    logic [2:0]  bCount;

    hit_info_align_queue #(.DEPTH(4), .BYPASS(0), .CHECK_SSID(1)) dutA (
        .clk(clk), .reset(reset),
        .push(aPush), .push_ssid(aPushSsid), .push_info(aPushInfo),
        .pop(aPop), .pop_ssid(aPopSsid), .clear_flags(aClr),
        .head_valid(aHeadValid), .head_info(aHeadInfo), .head_ssid(aHeadSsid),
        .count(aCount), .empty(aEmpty), .full(aFull), .almost_full(aAf),
        .overflow(aOvf), .underflow(aUdf), .mismatch(aMis), .mismatch_pulse(aMisP)
    );

    hit_info_align_queue #(.DEPTH(4), .BYPASS(1), .CHECK_SSID(1)) dutB (
        .clk(clk), .reset(reset),
        .push(bPush), .push_ssid(bPushSsid), .push_info(bPushInfo),
        .pop(bPop), .pop_ssid(bPopSsid), .clear_flags(bClr),
        .head_valid(bHeadValid), .head_info(bHeadInfo), .head_ssid(bHeadSsid),
        .count(bCount), .empty(bEmpty), .full(bFull), .almost_full(bAf),
        .overflow(bOvf), .underflow(bUdf), .mismatch(bMis), .mismatch_pulse(bMisP)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] qi [$];
    logic [12:0] qs [$];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setA(input logic ps, input logic [12:0] pss, input logic [15:0] pin,
                        input logic pp, input logic [12:0] pps, input logic clr);
        aPush = ps; aPushSsid = pss; aPushInfo = pin;
        aPop = pp; aPopSsid = pps; aClr = clr;
    endtask

    task automatic setB(input logic ps, input logic [12:0] pss, input logic [15:0] pin,
                        input logic pp, input logic [12:0] pps, input logic clr);
        bPush = ps; bPushSsid = pss; bPushInfo = pin;
        bPop = pp; bPopSsid = pps; bClr = clr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        setA(1'b0, 13'd0, 16'h0, 1'b0, 13'd0, 1'b0);
        setB(1'b0, 13'd0, 16'h0, 1'b0, 13'd0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        checkVal("rst_count", 32'(aCount), 32'd0);
        checkVal("rst_empty", 32'(aEmpty), 32'd1);
        checkVal("rst_full", 32'(aFull), 32'd0);
        checkVal("rst_af", 32'(aAf), 32'd0);
        checkVal("rst_hvalid", 32'(aHeadValid), 32'd0);
        checkVal("rst_hinfo", 32'(aHeadInfo), 32'd0);
        checkVal("rst_hssid", 32'(aHeadSsid), 32'd0);
        checkVal("rst_flags", 32'({aOvf, aUdf, aMis, aMisP}), 32'd0);

        // three pushes then three matching pops
        setA(1'b1, 13'd5, 16'hA1, 1'b0, 13'd0, 1'b0); tick();
        checkVal("t1_cnt1", 32'(aCount), 32'd1);
        checkVal("t1_head1", 32'(aHeadInfo), 32'hA1);
        checkVal("t1_af1", 32'(aAf), 32'd0);
        setA(1'b1, 13'd6, 16'hA2, 1'b0, 13'd0, 1'b0); tick();
        checkVal("t1_cnt2", 32'(aCount), 32'd2);
        checkVal("t1_af2", 32'(aAf), 32'd1);
        setA(1'b1, 13'd7, 16'hA3, 1'b0, 13'd0, 1'b0); tick();
        checkVal("t1_cnt3", 32'(aCount), 32'd3);
        setA(1'b0, 13'd0, 16'h0, 1'b1, 13'd5, 1'b0); #1;
        checkVal("t1_pop_a1", 32'(aHeadInfo), 32'hA1);
        tick();
        checkVal("t1_cnt2b", 32'(aCount), 32'd2);
        checkVal("t1_pop_a2", 32'(aHeadInfo), 32'hA2);
        setA(1'b0, 13'd0, 16'h0, 1'b1, 13'd6, 1'b0); tick();
        checkVal("t1_cnt1b", 32'(aCount), 32'd1);
        checkVal("t1_pop_a3", 32'(aHeadInfo), 32'hA3);
        setA(1'b0, 13'd0, 16'h0, 1'b1, 13'd7, 1'b0); tick();
        checkVal("t1_cnt0", 32'(aCount), 32'd0);
        checkVal("t1_empty", 32'(aEmpty), 32'd1);
        checkVal("t1_mis", 32'(aMis), 32'd0);
        checkVal("t1_hvalid", 32'(aHeadValid), 32'd0);

        // fill to full, then drop a push
        for (int i = 0; i < 4; i++) begin
            setA(1'b1, 13'(1 + i), 16'(16'h10 + i), 1'b0, 13'd0, 1'b0); tick();
            qi.push_back(16'(16'h10 + i));
            qs.push_back(13'(1 + i));
        end
        checkVal("t2_full", 32'(aFull), 32'd1);
        checkVal("t2_cnt4", 32'(aCount), 32'd4);
        checkVal("t2_ovf0", 32'(aOvf), 32'd0);
        setA(1'b1, 13'd9, 16'h99, 1'b0, 13'd0, 1'b0); tick();
        checkVal("t2_ovf1", 32'(aOvf), 32'd1);
        checkVal("t2_cnt_drop", 32'(aCount), 32'd4);
        checkVal("t2_head_kept", 32'(aHeadInfo), 32'h10);
        setA(1'b1, 13'd9, 16'h99, 1'b0, 13'd0, 1'b1); tick();
        checkVal("t2_ovf_err_wins", 32'(aOvf), 32'd1);
        setA(1'b0, 13'd0, 16'h0, 1'b0, 13'd0, 1'b1); tick();
        checkVal("t2_ovf_clr", 32'(aOvf), 32'd0);

        // full queue, push and pop together for 8 cycles
        for (int i = 0; i < 8; i++) begin
            setA(1'b1, 13'(10 + i), 16'(16'h20 + i), 1'b1, qs[0], 1'b0); #1;
            checkVal("t3_head", 32'(aHeadInfo), 32'(qi[0]));
            tick();
            void'(qi.pop_front());
            void'(qs.pop_front());
            qi.push_back(16'(16'h20 + i));
            qs.push_back(13'(10 + i));
            checkVal("t3_cnt", 32'(aCount), 32'd4);
        end
        checkVal("t3_ovf", 32'(aOvf), 32'd0);
        checkVal("t3_mis", 32'(aMis), 32'd0);
        for (int i = 0; i < 4; i++) begin
            setA(1'b0, 13'd0, 16'h0, 1'b1, qs[0], 1'b0); #1;
            checkVal("t3_drain", 32'(aHeadInfo), 32'(16'h24 + i));
            tick();
            void'(qi.pop_front());
            void'(qs.pop_front());
        end
        checkVal("t3_cnt0", 32'(aCount), 32'd0);
        checkVal("t3_mis_end", 32'(aMis), 32'd0);

        // pop on an empty queue, then push+pop on an empty queue
        setA(1'b0, 13'd0, 16'h0, 1'b1, 13'h1F, 1'b0); tick();
        checkVal("t4_udf", 32'(aUdf), 32'd1);
        checkVal("t4_cnt", 32'(aCount), 32'd0);
        checkVal("t4_mis", 32'(aMis), 32'd0);
        setA(1'b0, 13'd0, 16'h0, 1'b0, 13'd0, 1'b1); tick();
        checkVal("t4_udf_clr", 32'(aUdf), 32'd0);
        setA(1'b1, 13'h20, 16'h5A5A, 1'b1, 13'h20, 1'b0); #1;
        checkVal("t4_no_bypass", 32'(aHeadValid), 32'd0);
        tick();
        checkVal("t4_cnt1", 32'(aCount), 32'd1);
        checkVal("t4_hvalid", 32'(aHeadValid), 32'd1);
        checkVal("t4_hinfo", 32'(aHeadInfo), 32'h5A5A);
        checkVal("t4_udf2", 32'(aUdf), 32'd1);
        setA(1'b0, 13'd0, 16'h0, 1'b1, 13'h20, 1'b1); tick();
        checkVal("t4_cnt0", 32'(aCount), 32'd0);
        checkVal("t4_udf_clr2", 32'(aUdf), 32'd0);

        // SSID mismatch
        setA(1'b1, 13'd3, 16'h0333, 1'b0, 13'd0, 1'b0); tick();
        setA(1'b0, 13'd0, 16'h0, 1'b1, 13'd4, 1'b0); #1;
        checkVal("t5_hssid", 32'(aHeadSsid), 32'd3);
        tick();
        checkVal("t5_misp1", 32'(aMisP), 32'd1);
        checkVal("t5_mis1", 32'(aMis), 32'd1);
        checkVal("t5_cnt0", 32'(aCount), 32'd0);
        setA(1'b0, 13'd0, 16'h0, 1'b0, 13'd0, 1'b0); tick();
        checkVal("t5_misp0", 32'(aMisP), 32'd0);
        checkVal("t5_mis_sticky", 32'(aMis), 32'd1);
        setA(1'b0, 13'd0, 16'h0, 1'b0, 13'd0, 1'b1); tick();
        checkVal("t5_mis_clr", 32'(aMis), 32'd0);

        // reset mid-stream with flags set
        for (int i = 0; i < 5; i++) begin
            setA(1'b1, 13'(20 + i), 16'(16'h40 + i), 1'b0, 13'd0, 1'b0); tick();
        end
        setA(1'b0, 13'd0, 16'h0, 1'b1, 13'd0, 1'b0); tick();
        checkVal("t6_cnt3", 32'(aCount), 32'd3);
        checkVal("t6_ovf", 32'(aOvf), 32'd1);
        checkVal("t6_mis", 32'(aMis), 32'd1);
        setA(1'b1, 13'd1, 16'h1, 1'b0, 13'd0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        setA(1'b0, 13'd0, 16'h0, 1'b0, 13'd0, 1'b0);
        checkVal("t6_rst_cnt", 32'(aCount), 32'd0);
        checkVal("t6_rst_flags", 32'({aOvf, aUdf, aMis, aMisP}), 32'd0);
        checkVal("t6_rst_empty", 32'(aEmpty), 32'd1);
        checkVal("t6_rst_head", 32'({aHeadValid, aHeadInfo}), 32'd0);
        tick();
        checkVal("t6_rst_push_ign", 32'(aCount), 32'd0);

        // bypass instance
        setB(1'b1, 13'd9, 16'hBEEF, 1'b1, 13'd9, 1'b0); #1;
        checkVal("b1_hvalid", 32'(bHeadValid), 32'd1);
        checkVal("b1_hinfo", 32'(bHeadInfo), 32'hBEEF);
        checkVal("b1_hssid", 32'(bHeadSsid), 32'd9);
        tick();
        setB(1'b0, 13'd0, 16'h0, 1'b0, 13'd0, 1'b0);
        checkVal("b1_cnt", 32'(bCount), 32'd0);
        checkVal("b1_udf", 32'(bUdf), 32'd0);
        checkVal("b1_mis", 32'(bMis), 32'd0);
        checkVal("b1_empty", 32'(bEmpty), 32'd1);
        setB(1'b1, 13'd2, 16'h1234, 1'b0, 13'd0, 1'b0); #1;
        checkVal("b2_bypass_head", 32'(bHeadInfo), 32'h1234);
        tick();
        setB(1'b0, 13'd0, 16'h0, 1'b0, 13'd0, 1'b0);
        checkVal("b2_cnt", 32'(bCount), 32'd1);
        checkVal("b2_stored", 32'({bHeadValid, bHeadInfo}), 32'h11234);
        setB(1'b0, 13'd0, 16'h0, 1'b1, 13'd2, 1'b0); tick();
        setB(1'b0, 13'd0, 16'h0, 1'b0, 13'd0, 1'b0);
        checkVal("b3_cnt", 32'(bCount), 32'd0);
        checkVal("b3_flags", 32'({bOvf, bUdf, bMis, bFull, bAf}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
